sccb_responder: RTL and testbench

- SCCB target (camera-side) model: the responder end of the SCCB register-write link used for OV7670 configuration.
- Receives 3-phase writes and 2-phase-write/2-phase-read sequences on SIOC/SIOD, oversampled by the system clock.
- Stores written values in an internal 256x8 register file and reports every accepted write.
- Sits in the simulation/loopback fabric opposite the configuration master; used to self-check ROM-driven configuration and to emulate a sensor on boards without one.

---
 rtl/sccb_responder.sv | 201 ++++++++++++++++++++
 tb/tb_sccb_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder.sv
// SCCB target: receives 3-phase writes into a 256x8 register file and reports each accepted write.
// Define SCCB_RESPONDER_READ_EN to enable the 2-phase read (read ID = DEVICE_ID | 1).
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID     = 8'h42,
  parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc_i,
  input  logic       siod_i,
  output logic       siod_oe,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK, S_WAIT_STOP
`ifdef SCCB_RESPONDER_READ_EN
    , S_RD_DATA, S_RD_NA
`endif
  } state_e;

  state_e          state_q;
  logic [1:0]      scl_sync_q, sda_sync_q;
  logic            scl_hist_q, sda_hist_q;
  logic [2:0]      cnt_q;
  logic [6:0]      sh_q;
  logic            ack_ph_q;
  logic [AW-1:0]   sub_q;
  logic            clr_q;
  logic [AW-1:0]   clr_idx_q;
  logic [DW-1:0]   mem_q [DEPTH];
`ifdef SCCB_RESPONDER_READ_EN
  logic            rw_q;
  logic [DW-1:0]   rd_q;
`endif

  logic            scl_s_c, sda_s_c, scl_rise_c, scl_fall_c, start_c, stop_c;
  logic            id_match_c, wr_c;
  logic [DW-1:0]   byte_c;

  // Bus event decode from synchronised levels and one history flop
  always_comb begin
    scl_s_c    = scl_sync_q[1];
    sda_s_c    = sda_sync_q[1];
    scl_rise_c = scl_s_c & ~scl_hist_q;
    scl_fall_c = ~scl_s_c & scl_hist_q;
    start_c    = scl_s_c & scl_hist_q & sda_hist_q & ~sda_s_c;
    stop_c     = scl_s_c & scl_hist_q & ~sda_hist_q & sda_s_c;
    byte_c     = {sh_q, sda_s_c};
`ifdef SCCB_RESPONDER_READ_EN
    id_match_c = (byte_c[7:1] == DEVICE_ID[7:1]);
`else
    id_match_c = (byte_c[7:1] == DEVICE_ID[7:1]) && !byte_c[0];
`endif
    wr_c       = !reset && !clr_q && (state_q == S_DATA) && scl_rise_c && (cnt_q == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], sioc_i};
      sda_sync_q <= {sda_sync_q[0], siod_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      sh_q         <= 7'd0;
      ack_ph_q     <= 1'b0;
      sub_q        <= '0;
      siod_oe      <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 8'h00;
      reg_wr_data  <= 8'h00;
      busy         <= 1'b0;
      clr_q        <= 1'b1;
      clr_idx_q    <= '0;
`ifdef SCCB_RESPONDER_READ_EN
      rw_q         <= 1'b0;
      rd_q         <= '0;
`endif
    end else begin
      reg_wr_valid <= 1'b0;
      if (clr_q) begin
        // Clear sweep owns the register file; the bus is ignored meanwhile
        clr_idx_q <= clr_idx_q + AW'(1);
        busy      <= (clr_idx_q != AW'(DEPTH - 1));
        if (clr_idx_q == AW'(DEPTH - 1)) clr_q <= 1'b0;
      end else if (stop_c) begin
        state_q <= S_IDLE;
        siod_oe <= 1'b0;
        busy    <= 1'b0;
      end else if (start_c) begin
        state_q  <= S_ID;
        cnt_q    <= 3'd0;
        ack_ph_q <= 1'b0;
        siod_oe  <= 1'b0;
        busy     <= 1'b1;
      end else if (scl_rise_c) begin
        case (state_q)
          S_ID, S_SUB, S_DATA: begin
            sh_q  <= byte_c[6:0];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ack_ph_q <= 1'b0;
              if (state_q == S_ID) begin
                state_q <= id_match_c ? S_ID_ACK : S_WAIT_STOP;
`ifdef SCCB_RESPONDER_READ_EN
                rw_q <= byte_c[0];
                rd_q <= mem_q[sub_q];
`endif
              end else if (state_q == S_SUB) begin
                sub_q   <= byte_c;
                state_q <= S_SUB_ACK;
              end else begin
                reg_wr_valid <= 1'b1;
                reg_wr_addr  <= sub_q;
                reg_wr_data  <= byte_c;
                state_q      <= S_DATA_ACK;
              end
            end
          end
`ifdef SCCB_RESPONDER_READ_EN
          S_RD_DATA: begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= S_RD_NA;
          end
          S_RD_NA: state_q <= S_WAIT_STOP;
`endif
          default: ;
        endcase
      end else if (scl_fall_c) begin
        case (state_q)
          S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
            if (!ack_ph_q) begin
              siod_oe  <= 1'b1;
              ack_ph_q <= 1'b1;
            end else begin
              siod_oe  <= 1'b0;
              ack_ph_q <= 1'b0;
              if (state_q == S_ID_ACK) begin
`ifdef SCCB_RESPONDER_READ_EN
                if (rw_q) begin
                  // Present read bit 7 on the falling edge that closes the ACK clock
                  state_q <= S_RD_DATA;
                  siod_oe <= ~rd_q[7];
                  rd_q    <= {rd_q[6:0], 1'b0};
                end else begin
                  state_q <= S_SUB;
                end
`else
                state_q <= S_SUB;
`endif
              end else if (state_q == S_SUB_ACK) begin
                state_q <= S_DATA;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end
          end
`ifdef SCCB_RESPONDER_READ_EN
          S_RD_DATA: begin
            siod_oe <= ~rd_q[7];
            rd_q    <= {rd_q[6:0], 1'b0};
          end
          S_RD_NA: siod_oe <= 1'b0;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_q) mem_q[clr_idx_q] <= REG_RESET_VAL;
    else if (wr_c) mem_q[sub_q] <= byte_c;
  end

  always_ff @(posedge clk) begin
    if (reset) dbg_data <= REG_RESET_VAL;
    else       dbg_data <= mem_q[dbg_addr];
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-level SCCB master, write scoreboard and register peeks.
// Read-back expectations follow SCCB_RESPONDER_READ_EN.
module tb_sccb_responder;

  logic       clk, reset;
  logic       scl_m, sda_m;
  logic       siod_oe, reg_wr_valid, busy;
  logic [7:0] reg_wr_addr, reg_wr_data, dbg_addr, dbg_data;
  wire        sda_line = sda_m & ~siod_oe;

  int n_vec = 0;
  int n_bad = 0;
  int oe_cnt = 0;
  logic [15:0] exp_q [$];

  sccb_responder #(.DEVICE_ID(8'h42), .REG_RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .sioc_i(scl_m), .siod_i(sda_line),
    .siod_oe(siod_oe), .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (siod_oe) oe_cnt++;

  // Write monitor: every reg_wr_valid pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && reg_wr_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", reg_wr_addr, reg_wr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({reg_wr_addr, reg_wr_data} !== e) begin
          n_bad++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   reg_wr_addr, reg_wr_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One SIOC period = 16 clk; SIOD only moves while SIOC is low
  task automatic send_bit(input logic b, output logic s);
    wclk(4); sda_m = b;
    wclk(4); scl_m = 1'b1;
    wclk(4); s = sda_line;
    wclk(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b0; wclk(8); scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    wclk(4); sda_m = 1'b1;
    wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b0;
    wclk(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wclk(4); sda_m = 1'b0;
    wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b1;
    wclk(8);
  endtask

  task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    wclk(2);
    check(name, {8'h00, dbg_data}, {8'h00, exp});
  endtask

  task automatic write3(input logic [7:0] sub, input logic [7:0] dat, input string tag);
    logic ack;
    exp_q.push_back({sub, dat});
    bus_start();
    send_byte(8'h42, ack); check({tag, "_id_ack"},   {15'd0, ack}, 16'd0);
    send_byte(sub, ack);   check({tag, "_sub_ack"},  {15'd0, ack}, 16'd0);
    send_byte(dat, ack);   check({tag, "_data_ack"}, {15'd0, ack}, 16'd0);
    bus_stop();
  endtask

  initial begin
    logic ack, s;
    logic [7:0] rd;
    int oe_before;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 8'h00;
    wclk(3);
    check("reset_oe",    {15'd0, siod_oe},      16'd0);
    check("reset_valid", {15'd0, reg_wr_valid}, 16'd0);
    check("reset_busy",  {15'd0, busy},         16'd0);
    check("reset_dbg",   {8'h00, dbg_data},     16'h0000);
    reset = 1'b0;
    wclk(10);
    check("sweep_busy", {15'd0, busy}, 16'd1);
    wclk(260);
    check("sweep_done_busy", {15'd0, busy}, 16'd0);
    for (int a = 0; a < 256; a++) peek("sweep_clear", 8'(a), 8'h00);

    // Basic 3-phase write
    write3(8'h12, 8'h80, "w12");
    wclk(8);
    check("w12_busy_after_stop", {15'd0, busy}, 16'd0);
    peek("w12_peek", 8'h12, 8'h80);

    // Foreign ID: nothing driven, nothing written
    oe_before = oe_cnt;
    bus_start();
    send_byte(8'h60, ack); check("wrong_id_ack",  {15'd0, ack}, 16'd1);
    check("wrong_id_busy", {15'd0, busy}, 16'd1);
    send_byte(8'h12, ack); check("wrong_id_ack2", {15'd0, ack}, 16'd1);
    send_byte(8'h34, ack); check("wrong_id_ack3", {15'd0, ack}, 16'd1);
    bus_stop();
    check("wrong_id_oe_cycles", 16'(oe_cnt - oe_before), 16'd0);
    check("wrong_id_busy_after", {15'd0, busy}, 16'd0);
    peek("wrong_id_reg12", 8'h12, 8'h80);

    // Read-back through the sub-address latch
    write3(8'h3A, 8'h04, "w3a");
    bus_start();
    send_byte(8'h42, ack); check("rd_setup_id_ack",  {15'd0, ack}, 16'd0);
    send_byte(8'h3A, ack); check("rd_setup_sub_ack", {15'd0, ack}, 16'd0);
    bus_stop();
    bus_start();
    send_byte(8'h43, ack);
    read_byte(rd);
    send_bit(1'b1, s);
`ifdef SCCB_RESPONDER_READ_EN
    check("rd_id_ack", {15'd0, ack}, 16'd0);
    check("rd_data",   {8'h00, rd},  16'h0004);
`else
    check("rd_id_ack", {15'd0, ack}, 16'd1);
    check("rd_data",   {8'h00, rd},  16'h00FF);
`endif
    check("rd_na_released", {15'd0, s}, 16'd1);
    bus_stop();
    check("rd_oe_after_stop", {15'd0, siod_oe}, 16'd0);

    // Abort: STOP after 5 data bits
    bus_start();
    send_byte(8'h42, ack); check("abort_id_ack",  {15'd0, ack}, 16'd0);
    send_byte(8'h20, ack); check("abort_sub_ack", {15'd0, ack}, 16'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, s);
    bus_stop();
    peek("abort_reg20", 8'h20, 8'h00);

    // Repeated START in the middle of the sub-address
    bus_start();
    send_byte(8'h42, ack); check("rs_id_ack", {15'd0, ack}, 16'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, s);
    bus_rstart();
    exp_q.push_back({8'h55, 8'hAA});
    send_byte(8'h42, ack); check("rs2_id_ack",   {15'd0, ack}, 16'd0);
    send_byte(8'h55, ack); check("rs2_sub_ack",  {15'd0, ack}, 16'd0);
    send_byte(8'hAA, ack); check("rs2_data_ack", {15'd0, ack}, 16'd0);
    bus_stop();
    peek("rs_reg55", 8'h55, 8'hAA);

    // Reset while the DATA ACK is being driven (commit already made at bit 8)
    exp_q.push_back({8'h30, 8'h77});
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h30, ack);
    rd = 8'h77;
    for (int i = 7; i >= 0; i--) send_bit(rd[i], s);
    wclk(4);
    check("ack_oe_before_reset", {15'd0, siod_oe}, 16'd1);
    reset = 1'b1;
    wclk(1);
    check("reset_releases_oe", {15'd0, siod_oe}, 16'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    wclk(2);
    reset = 1'b0;
    wclk(270);
    check("post_reset_busy", {15'd0, busy}, 16'd0);
    peek("post_reset_reg30", 8'h30, 8'h00);
    peek("post_reset_reg55", 8'h55, 8'h00);
    write3(8'h31, 8'h5A, "w31");
    peek("w31_peek", 8'h31, 8'h5A);

    wclk(4);
    check("writes_outstanding", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
